spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Byte-level command controller behind the SPI slave byte interface. Turns the received byte stream of each chip-select frame into register-file reads and writes, and feeds read data back to the SPI transmit side through its valid/ready handshake. It sits between the SPI receiver and a single-cycle-latency register file. It owns all framing, addressing and read-prefetch sequencing, so the register file never sees SPI timing.

## Interface
Parameters:
- ADDR_WIDTH, 7: register address width, legal range 1..7; command byte bits [ADDR_WIDTH-1:0] carry the start address.

Ports:
- clock  in  1: system clock; single clock domain.
- reset  in  1: synchronous, active-high.
- frame_start  in  1: one-cycle pulse on chip-select assertion.
- frame_end  in  1: one-cycle pulse on chip-select deassertion.
- in_data_valid  in  1: one-cycle pulse, received byte on in_data; no backpressure.
- in_data  in  8: received byte.
- out_data_valid  out  1: transmit byte offered.
- out_data  out  8: transmit byte.
- out_data_ready  in  1: transmit side can accept; transfer on valid & ready.
- reg_addr  out  ADDR_WIDTH: register address.
- reg_wdata  out  8: write data.
- reg_we  out  1: one-cycle write strobe.
- reg_re  out  1: one-cycle read strobe.
- reg_rdata  in  8: read data, valid exactly one cycle after reg_re.
- busy  out  1: high while not in IDLE.
- frame_bytes  out  8: bytes received in current or last frame, saturating at 255.

## Operation
- Reset values: every output is 0. State is IDLE.
- FSM states: IDLE, CMD, WR, RD_FETCH, RD_WAIT, RD_OFFER.
- IDLE -> CMD on frame_start. In IDLE, in_data_valid is ignored.
- CMD: the first in_data_valid is the command byte. Bit 7 = 1 selects read, 0 selects write. reg_addr loads from in_data[ADDR_WIDTH-1:0]. Write goes to WR; read goes to RD_FETCH.
- WR: each in_data_valid drives reg_we=1, reg_wdata=in_data and the current reg_addr for one cycle. The address then advances.
- RD_FETCH: reg_re=1 for one cycle, then RD_WAIT.
- RD_WAIT: latch reg_rdata into out_data, set out_data_valid=1, then RD_OFFER.
- RD_OFFER: hold out_data and out_data_valid until valid & ready. On the transfer, drop valid, advance the address and go to RD_FETCH. During read frames, received bytes are dummy bytes and are discarded; they are still counted.
- Address advance: +1 modulo 2^ADDR_WIDTH. After all-ones the address wraps to 0.
- frame_bytes clears on frame_start and increments on each in_data_valid in non-IDLE states, saturating at 255. It holds its value after frame_end.
- frame_end in any state goes to IDLE. It clears out_data_valid and aborts any pending fetch: a reg_rdata arriving after an abort is dropped. If frame_end coincides with in_data_valid, frame_end wins; the byte is neither written nor counted.
- frame_start in a non-IDLE state restarts the frame: go to CMD, clear the counter, drop out_data_valid.
- frame_start and frame_end in the same cycle: frame_end wins.
- Reset mid-frame: all outputs return to reset values the next cycle. No strobe is issued.

## Timing
- Write latency: in_data_valid at cycle t gives reg_we at t+1.
- Read: command byte at t gives reg_re at t+1, reg_rdata sampled at t+2, out_data_valid at t+3.
- Next byte: a handshake at cycle u gives reg_re at u+1 and out_data_valid at u+3.
- reg_we and reg_re are never high together. Each is high for exactly one cycle per access.
- out_data is stable whenever out_data_valid is high.

## Configuration
- SPI_REG_CTRL_AUTOINC_EN defined: the address advances after every write strobe and every read transfer, as above.
- SPI_REG_CTRL_AUTOINC_EN undefined: reg_addr stays at the command address for the whole frame (FIFO-port style). All other behaviour is identical.

## Structure
- Shared package spi_pkg holds the FSM state encodings, the command read bit index (7) and the byte width constant (8).
- No sub-module; a single FSM plus address and counter registers.

## Test plan
- Write burst: frame_start, bytes 0x05,0xAA,0xBB, frame_end -> reg_we twice at addresses 0x05 and 0x06 with data 0xAA and 0xBB; frame_bytes=3.
- Read: command 0x90, regfile[0x10]=0x3C, regfile[0x11]=0x4D, ready pulses -> out_data 0x3C then 0x4D; reg_re exactly at t+1 and at each handshake+1.
- Wrap: write command 0x7F with 2 data bytes (ADDR_WIDTH=7) -> writes at 0x7F, then 0x00. With the macro off, both writes go to 0x7F.
- Abort: frame_end while in RD_WAIT -> out_data_valid stays 0, state IDLE, busy=0 next cycle.
- Collision: frame_end in the same cycle as a data byte in WR -> no reg_we, frame_bytes unchanged.
- Saturation and reset: 300 bytes in one frame -> frame_bytes=255. A reset pulse mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/spi_reg_ctrl_pkg.sv
// Shared definitions for the SPI register controller: byte width, command
// read-bit position, FSM state encoding and a saturating byte counter helper.
package spi_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_RD_BIT = 7;
  localparam logic [BYTE_W-1:0] BYTE_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_WR       = 3'd2,
    ST_RD_FETCH = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_OFFER = 3'd5
  } state_t;

  // Increment a byte counter, sticking at all-ones instead of wrapping.
  function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
    logic [BYTE_W-1:0] r;
    if (v == BYTE_MAX) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Bundle of the SPI byte stream, transmit handshake and register-file bus.
// The slave modport is the controller's view; master is the environment's.
interface spi_reg_ctrl_if
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) ();

  logic                  frame_start;
  logic                  frame_end;
  logic                  in_data_valid;
  logic [BYTE_W-1:0]     in_data;
  logic                  out_data_valid;
  logic [BYTE_W-1:0]     out_data;
  logic                  out_data_ready;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [BYTE_W-1:0]     reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [BYTE_W-1:0]     reg_rdata;
  logic                  busy;
  logic [BYTE_W-1:0]     frame_bytes;

  modport slave (
    input  frame_start, frame_end, in_data_valid, in_data, out_data_ready, reg_rdata,
    output out_data_valid, out_data, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_bytes
  );

  modport master (
    output frame_start, frame_end, in_data_valid, in_data, out_data_ready, reg_rdata,
    input  out_data_valid, out_data, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_bytes
  );

endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI byte-stream to register-file command controller.
// Optional feature macro: SPI_REG_CTRL_AUTOINC_EN -- when defined the register
// address advances after each write strobe and each read transfer; otherwise
// the address stays at the command address for the whole frame.
// All outputs are registered; frame_end always has priority over frame_start
// and over a byte arriving in the same cycle.
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic           clock,
  input  logic           reset,
  spi_reg_ctrl_if.slave  bus
);

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  state_t                state_r;
  state_t                next_state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [BYTE_W-1:0]     wdata_r;
  logic                  we_r;
  logic                  re_r;
  logic [BYTE_W-1:0]     odata_r;
  logic                  ovalid_r;
  logic [BYTE_W-1:0]     count_r;
  logic                  busy_r;

  logic                  restart_s;
  logic                  byte_s;
  logic                  cmd_load_s;
  logic                  wr_hit_s;
  logic                  xfer_s;

  // Qualify incoming events: frame_end masks everything, a restart masks the byte.
  always_comb begin
    restart_s  = bus.frame_start & ~bus.frame_end;
    byte_s     = bus.in_data_valid & (state_r != ST_IDLE) & ~bus.frame_end & ~restart_s;
    cmd_load_s = byte_s & (state_r == ST_CMD);
    wr_hit_s   = byte_s & (state_r == ST_WR);
    xfer_s     = (state_r == ST_RD_OFFER) & ovalid_r & bus.out_data_ready &
                 ~bus.frame_end & ~restart_s;
  end

  // Next-state decode for the framing / read-prefetch sequencer.
  always_comb begin
    next_state_s = state_r;
    if (bus.frame_end) begin
      next_state_s = ST_IDLE;
    end else if (bus.frame_start) begin
      next_state_s = ST_CMD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          next_state_s = ST_IDLE;
        end
        ST_CMD: begin
          if (bus.in_data_valid) begin
            next_state_s = bus.in_data[CMD_RD_BIT] ? ST_RD_FETCH : ST_WR;
          end else begin
            next_state_s = ST_CMD;
          end
        end
        ST_WR:       next_state_s = ST_WR;
        ST_RD_FETCH: next_state_s = ST_RD_WAIT;
        ST_RD_WAIT:  next_state_s = ST_RD_OFFER;
        ST_RD_OFFER: begin
          if (xfer_s) begin
            next_state_s = ST_RD_FETCH;
          end else begin
            next_state_s = ST_RD_OFFER;
          end
        end
        default:     next_state_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered strobes, read-data holding register, address and byte counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_r   <= '0;
      wdata_r  <= 8'h00;
      we_r     <= 1'b0;
      re_r     <= 1'b0;
      odata_r  <= 8'h00;
      ovalid_r <= 1'b0;
      count_r  <= 8'h00;
      busy_r   <= 1'b0;
    end else begin
      we_r   <= wr_hit_s;
      re_r   <= (next_state_s == ST_RD_FETCH);
      busy_r <= (next_state_s != ST_IDLE);

      if (wr_hit_s) begin
        wdata_r <= bus.in_data;
      end

      // The fetched byte is only captured while the fetch is still live.
      if (bus.frame_end || bus.frame_start) begin
        ovalid_r <= 1'b0;
      end else if (state_r == ST_RD_WAIT) begin
        odata_r  <= bus.reg_rdata;
        ovalid_r <= 1'b1;
      end else if (xfer_s) begin
        ovalid_r <= 1'b0;
      end

      // Advance after the write strobe cycle so back-to-back bytes see the next address.
      if (cmd_load_s) begin
        addr_r <= bus.in_data[ADDR_WIDTH-1:0];
      end else if (AUTOINC && (we_r || xfer_s)) begin
        addr_r <= addr_r + ADDR_WIDTH'(1);
      end

      if (bus.frame_end) begin
        count_r <= count_r;
      end else if (bus.frame_start) begin
        count_r <= 8'h00;
      end else if (bus.in_data_valid && (state_r != ST_IDLE)) begin
        count_r <= sat_inc(count_r);
      end
    end
  end

  assign bus.reg_addr       = addr_r;
  assign bus.reg_wdata      = wdata_r;
  assign bus.reg_we         = we_r;
  assign bus.reg_re         = re_r;
  assign bus.out_data       = odata_r;
  assign bus.out_data_valid = ovalid_r;
  assign bus.frame_bytes    = count_r;
  assign bus.busy           = busy_r;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: table-driven write bursts, hand-written
// read / abort / collision / saturation / reset sequences, and scoreboard queues
// for register writes and transmitted read bytes.
module tb_spi_reg_ctrl;

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  spi_reg_ctrl_if #(.ADDR_WIDTH(7)) bus ();

  spi_reg_ctrl #(.ADDR_WIDTH(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
  } wexp_t;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [6:0] a0;
    logic [6:0] a1;
  } wvec_t;

  wexp_t      wq[$];
  logic [7:0] rq[$];
  logic [7:0] regfile [0:127];
  wvec_t      vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_addr(input logic [7:0] cmd, input int i);
    logic [7:0] s;
    if (AUTOINC) s = cmd + 8'(i);
    else         s = cmd;
    return s[6:0];
  endfunction

  // Register file model: single-cycle read latency, garbage when not read.
  always @(posedge clock) begin
    if (bus.reg_we) regfile[bus.reg_addr] <= bus.reg_wdata;
    bus.reg_rdata <= bus.reg_re ? regfile[bus.reg_addr] : 8'hE7;
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.reg_we) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_we actual addr=%0h data=%0h required=no write", bus.reg_addr, bus.reg_wdata);
        end else begin
          wexp_t e;
          e = wq.pop_front();
          chk("we_addr", 32'(bus.reg_addr), 32'(e.a));
          chk("we_data", 32'(bus.reg_wdata), 32'(e.d));
        end
      end
      if (bus.reg_we && bus.reg_re) begin
        checks++; failures++;
        $display("FAIL we_re_overlap actual=both high required=exclusive");
      end
      if (bus.out_data_valid && bus.out_data_ready) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_xfer actual=%0h required=no transfer", bus.out_data);
        end else begin
          chk("rd_xfer_data", 32'(bus.out_data), 32'(rq.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic start_frame();
    tick(); bus.frame_start = 1'b1;
    tick(); bus.frame_start = 1'b0;
  endtask

  task automatic end_frame();
    tick(); bus.frame_end = 1'b1;
    tick(); bus.frame_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(); bus.in_data_valid = 1'b1; bus.in_data = b;
    tick(); bus.in_data_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ovalid"}, 32'(bus.out_data_valid), 32'd0);
    chk({tag, "_odata"},  32'(bus.out_data), 32'd0);
    chk({tag, "_addr"},   32'(bus.reg_addr), 32'd0);
    chk({tag, "_wdata"},  32'(bus.reg_wdata), 32'd0);
    chk({tag, "_we"},     32'(bus.reg_we), 32'd0);
    chk({tag, "_re"},     32'(bus.reg_re), 32'd0);
    chk({tag, "_busy"},   32'(bus.busy), 32'd0);
    chk({tag, "_fbytes"}, 32'(bus.frame_bytes), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b;
    checks = 0; failures = 0;
    for (int i = 0; i < 128; i++) regfile[i] = 8'h00;
    bus.frame_start = 1'b0; bus.frame_end = 1'b0; bus.in_data_valid = 1'b0;
    bus.in_data = 8'h00; bus.out_data_ready = 1'b0;

    vecs[0] = '{8'h05, 8'hAA, 8'hBB, 7'h05, AUTOINC ? 7'h06 : 7'h05};
    vecs[1] = '{8'h7F, 8'h11, 8'h22, 7'h7F, AUTOINC ? 7'h00 : 7'h7F};
    vecs[2] = '{8'h00, 8'h33, 8'h44, 7'h00, AUTOINC ? 7'h01 : 7'h00};
    vecs[3] = '{8'h40, 8'h55, 8'h66, 7'h40, AUTOINC ? 7'h41 : 7'h40};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    chk_all_zero("reset");

    // Table-driven write bursts.
    for (int i = 0; i < 4; i++) begin
      start_frame();
      send_byte(vecs[i].cmd);
      wq.push_back('{vecs[i].a0, vecs[i].d0});
      send_byte(vecs[i].d0);
      wq.push_back('{vecs[i].a1, vecs[i].d1});
      send_byte(vecs[i].d1);
      tick(); tick();
      end_frame();
      @(negedge clock);
      chk("wr_fbytes", 32'(bus.frame_bytes), 32'd3);
      chk("wr_busy_after_end", 32'(bus.busy), 32'd0);
    end

    // Read burst with timing checks.
    regfile[7'h10] = 8'h3C;
    regfile[7'h11] = 8'h4D;
    start_frame();
    send_byte(8'h90);
    rq.push_back(8'h3C);
    @(negedge clock);
    chk("rd_re_t1", 32'(bus.reg_re), 32'd1);
    chk("rd_addr_t1", 32'(bus.reg_addr), 32'h10);
    @(negedge clock);
    chk("rd_re_t2", 32'(bus.reg_re), 32'd0);
    chk("rd_valid_t2", 32'(bus.out_data_valid), 32'd0);
    @(negedge clock);
    chk("rd_valid_t3", 32'(bus.out_data_valid), 32'd1);
    chk("rd_data_t3", 32'(bus.out_data), 32'h3C);
    send_byte(8'hFF);
    @(negedge clock);
    chk("rd_hold_valid", 32'(bus.out_data_valid), 32'd1);
    chk("rd_hold_data", 32'(bus.out_data), 32'h3C);
    chk("rd_dummy_count", 32'(bus.frame_bytes), 32'd2);
    exp_b = AUTOINC ? 8'h4D : 8'h3C;
    tick(); bus.out_data_ready = 1'b1;
    rq.push_back(exp_b);
    tick(); bus.out_data_ready = 1'b0;
    @(negedge clock);
    chk("rd_re_u1", 32'(bus.reg_re), 32'd1);
    chk("rd_addr_u1", 32'(bus.reg_addr), AUTOINC ? 32'h11 : 32'h10);
    chk("rd_valid_u1", 32'(bus.out_data_valid), 32'd0);
    @(negedge clock);
    chk("rd_valid_u2", 32'(bus.out_data_valid), 32'd0);
    @(negedge clock);
    chk("rd_valid_u3", 32'(bus.out_data_valid), 32'd1);
    chk("rd_data_u3", 32'(bus.out_data), 32'(exp_b));
    tick(); bus.out_data_ready = 1'b1;
    tick(); bus.out_data_ready = 1'b0;
    end_frame();
    @(negedge clock);
    chk("rd_end_valid", 32'(bus.out_data_valid), 32'd0);

    // Abort while the fetch is in RD_WAIT.
    start_frame();
    send_byte(8'h90);
    tick(); bus.frame_end = 1'b1;
    tick(); bus.frame_end = 1'b0;
    @(negedge clock);
    chk("abort_valid", 32'(bus.out_data_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    tick(); tick();
    @(negedge clock);
    chk("abort_valid_late", 32'(bus.out_data_valid), 32'd0);

    // frame_end colliding with a data byte.
    start_frame();
    send_byte(8'h20);
    wq.push_back('{7'h20, 8'h77});
    send_byte(8'h77);
    tick(); bus.in_data_valid = 1'b1; bus.in_data = 8'h99; bus.frame_end = 1'b1;
    tick(); bus.in_data_valid = 1'b0; bus.frame_end = 1'b0;
    @(negedge clock);
    chk("coll_no_we", 32'(bus.reg_we), 32'd0);
    chk("coll_fbytes", 32'(bus.frame_bytes), 32'd2);
    chk("coll_busy", 32'(bus.busy), 32'd0);

    // 300-byte frame saturates the counter.
    start_frame();
    send_byte(8'h01);
    for (int i = 0; i < 299; i++) begin
      wq.push_back('{exp_addr(8'h01, i), 8'(i)});
      send_byte(8'(i));
    end
    @(negedge clock);
    chk("sat_fbytes", 32'(bus.frame_bytes), 32'd255);
    end_frame();
    @(negedge clock);
    chk("sat_hold_after_end", 32'(bus.frame_bytes), 32'd255);

    // Reset while a read byte is offered.
    start_frame();
    send_byte(8'h90);
    for (int k = 0; k < 10 && !bus.out_data_valid; k++) @(negedge clock);
    chk("rst_wait_valid", 32'(bus.out_data_valid), 32'd1);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clock);
    chk_all_zero("midrst");
    tick(); tick();
    @(negedge clock);
    chk("midrst_no_re", 32'(bus.reg_re), 32'd0);
    chk("midrst_no_valid", 32'(bus.out_data_valid), 32'd0);

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
